// File: rtl/alu_pkg.sv
// Shared constants and types for the multi-cycle ALU.
package alu_pkg;

    // Default operand width in bits.
    localparam int ALU_DEFAULT_WIDTH = 32;

    // Operation codes carried on ctrl; 4'b1100..4'b1111 are illegal.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_ROL = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } alu_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock. done_o is high in the cycle
// of the final iteration; quotient_o/remainder_o carry the final values then,
// so the parent can capture them on the same edge that ends the iteration.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] step_quo_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             last_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted_s  = {rem_q, quo_q[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, dvs_q};
        step_quo_s = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
        if (diff_s[WIDTH]) begin
            step_rem_s = shifted_s[WIDTH-1:0];
        end else begin
            step_rem_s = diff_s[WIDTH-1:0];
        end
        last_s = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Load on start, otherwise iterate until the counter reaches WIDTH.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            quo_d = step_quo_s;
            rem_d = step_rem_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_s) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done_o      = last_s;
    assign quotient_o  = step_quo_s;
    assign remainder_o = step_rem_s;

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add multiply and a
// restoring divide. Results and flags are captured on the edge entering DONE.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ZLO,
    output logic [WIDTH-1:0] ZHI,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             illegal_op
);

    alu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic             accept_s;
    logic             div_start_s;
    logic             div_done_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH-1:0] sc_lo_s;
    logic [WIDTH-1:0] sc_hi_s;
    logic             sc_dbz_s;
    logic             sc_ill_s;

    assign accept_s = start && !busy_q;

    seq_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (clr),
        .start_i     (div_start_s),
        .dividend_i  (A),
        .divisor_i   (B),
        .done_o      (div_done_s),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s)
    );

    // Shift-add step: add multiplicand if the current multiplier bit is set, shift right.
    always_comb begin
        if (acc_lo_q[0]) begin
            mul_sum_s = {1'b0, acc_hi_q} + {1'b0, mcand_q};
        end else begin
            mul_sum_s = {1'b0, acc_hi_q};
        end
        mul_hi_s = mul_sum_s[WIDTH:1];
        mul_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
    end

    // Results of the ops that finish straight from IDLE (incl. div by zero, illegal).
    always_comb begin
        sc_lo_s  = '0;
        sc_hi_s  = '0;
        sc_dbz_s = 1'b0;
        sc_ill_s = 1'b0;
        case (ctrl)
            OP_ADD: sc_lo_s = A + B;
            OP_SUB: sc_lo_s = A - B;
            OP_MUL: sc_lo_s = '0;
            OP_DIV: begin
                sc_lo_s  = '1;
                sc_hi_s  = A;
                sc_dbz_s = 1'b1;
            end
            OP_SHR: sc_lo_s = {1'b0, A[WIDTH-1:1]};
            OP_SHL: sc_lo_s = {A[WIDTH-2:0], 1'b0};
            OP_ROR: sc_lo_s = {A[0], A[WIDTH-1:1]};
            OP_ROL: sc_lo_s = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_AND: sc_lo_s = A & B;
            OP_OR:  sc_lo_s = A | B;
            OP_NEG: sc_lo_s = '0 - A;
            OP_NOT: sc_lo_s = ~A;
            default: sc_ill_s = 1'b1;
        endcase
    end

    // Sequencer next state, datapath updates and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        zlo_d       = zlo_q;
        zhi_d       = zhi_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        div_start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (ctrl == OP_MUL) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        mcand_d  = A;
                        acc_hi_d = '0;
                        acc_lo_d = B;
                    end else if ((ctrl == OP_DIV) && (B != '0)) begin
                        state_d     = DIV;
                        div_start_s = 1'b1;
                    end else begin
                        state_d = DONE;
                        zlo_d   = sc_lo_s;
                        zhi_d   = sc_hi_s;
                        dbz_d   = sc_dbz_s;
                        ill_d   = sc_ill_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_hi_d = mul_hi_s;
                acc_lo_d = mul_lo_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    zlo_d   = mul_lo_s;
                    zhi_d   = mul_hi_s;
                    dbz_d   = 1'b0;
                    ill_d   = 1'b0;
                end else begin
                    state_d = MUL;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_d = DONE;
                    zlo_d   = div_quo_s;
                    zhi_d   = div_rem_s;
                    dbz_d   = 1'b0;
                    ill_d   = 1'b0;
                end else begin
                    state_d = DIV;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers; clr clears everything at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            zlo_q    <= '0;
            zhi_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            zlo_q    <= zlo_d;
            zhi_q    <= zhi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    assign ZLO         = zlo_q;
    assign ZHI         = zhi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal values: even, 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.

Interface
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request; A, B and ctrl are sampled when start=1 and busy=0.
REQ-006 ctrl  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 shr, 0101 shl, 0110 ror, 0111 rol, 1000 and, 1001 or, 1010 neg, 1011 not; 1100-1111 illegal.
REQ-007 A, B  input  WIDTH  unsigned operands.
REQ-008 ZLO, ZHI  output  WIDTH  registered result, low and high halves.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done is high (inclusive).
REQ-010 done  output  1  one-cycle pulse; the result is valid in the same cycle.
REQ-011 div_by_zero  output  1  registered flag; updated with done, high only for a div with B=0.
REQ-012 illegal_op  output  1  registered flag; updated with done, high only for opcodes 1100-1111.

Function
REQ-013 A start while busy=1 SHALL be ignored, and operands SHALL NOT be re-sampled.
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and DONE; transitions are as follows.
- IDLE to DONE: single-cycle op.
- IDLE to MUL: ctrl=0010.
- IDLE to DIV: ctrl=0011 with B!=0.
- IDLE to DONE: ctrl=0011 with B=0.
- MUL or DIV to DONE: when the counter reaches WIDTH.
- DONE to IDLE: unconditionally.
REQ-015 In DONE, done SHALL be 1 and busy SHALL be 1; in IDLE, both SHALL be 0.
REQ-016 Single-cycle ops and illegal ops SHALL assert done 2 cycles after the start edge.
REQ-017 mul and div SHALL assert done WIDTH+2 cycles after the start edge.
REQ-018 add and sub SHALL produce ZLO = (A±B) mod 2^WIDTH and ZHI = 0; the carry and borrow are discarded.
REQ-019 mul SHALL be a shift-add multiplier, one partial product per cycle, producing {ZHI,ZLO} = A*B over the full 2*WIDTH bits.
REQ-020 div SHALL be a restoring divider producing one quotient bit per cycle, with ZLO = A/B and ZHI = A%B.
REQ-021 A div with B=0 SHALL produce ZLO = all-ones, ZHI = A and div_by_zero = 1.
REQ-022 shr and shl SHALL be 1-bit logical shifts (zero fill), and ror and rol SHALL be 1-bit rotates; for these ops ZHI = 0.
REQ-023 and and or SHALL be bitwise; for these ops ZHI = 0.
REQ-024 neg SHALL produce ZLO = two's complement (−A); not SHALL produce ZLO = bitwise ~A; for these ops ZHI = 0.
REQ-025 Illegal opcodes SHALL produce ZLO = ZHI = 0 and illegal_op = 1.
REQ-026 ZLO, ZHI, div_by_zero and illegal_op SHALL change only on the cycle done is asserted, and SHALL hold until the next done.
REQ-027 A start in the cycle done is high SHALL be ignored, because busy=1.
REQ-028 A start in the IDLE cycle immediately after done SHALL be accepted.

Reset
REQ-029 Assertion of clr (clr=0) SHALL immediately set the FSM to IDLE, the counter to 0, and ZLO, ZHI, busy, done, div_by_zero and illegal_op to 0.
REQ-030 Reset mid-operation SHALL abandon the operation, with no done pulse.
REQ-031 The first start SHALL be accepted in the cycle after clr deasserts.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode constants, the FSM state type and the default WIDTH.
REQ-033 The restoring divider datapath (remainder, quotient and counter) SHALL be sub-module seq_divider, with a start/done interface; multiply SHALL remain inline.

Verification
REQ-034 WIDTH=32, add with A=0xFFFFFFFF, B=1 -> ZLO=0, ZHI=0, done 2 cycles after start.
REQ-035 mul with A=0xFFFFFFFF, B=0xFFFFFFFF -> ZHI=0xFFFFFFFE, ZLO=0x00000001, done at cycle 34.
REQ-036 div with A=100, B=7 -> ZLO=14, ZHI=2, div_by_zero=0, done at cycle 34; then div with B=0, A=5 -> ZLO=0xFFFFFFFF, ZHI=5, div_by_zero=1, done at cycle 2.
REQ-037 ror with A=1 -> ZLO=0x80000000; neg with A=1 -> ZLO=0xFFFFFFFF; not with A=0 -> ZLO=0xFFFFFFFF; ctrl=1110 -> illegal_op=1, ZLO=0.
REQ-038 Start mul, then a second start with different operands 5 cycles later -> ignored; only the first result appears.
REQ-039 Start div, then assert clr at cycle 10 -> all outputs 0, no done; a new add accepted after release completes correctly.
